// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: FSM encoding,
// the hard-wired zero register and the write-request bundle.
package wb_port_arbiter_pkg;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

    // Register $0 is hard-wired; writes to it are dropped.
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One register-file write request at the default port widths.
    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between write-back stage, MDU, arbiter and register file.
// The arbiter uses the slave view; whoever drives pipeline/MDU uses master.
interface wb_port_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              pipe_stall;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
        output mdu_ready, rf_we, rf_addr, rf_data, pipe_stall, fifo_count
    );

    modport master (
        output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready, rf_we, rf_addr, rf_data, pipe_stall, fifo_count
    );
endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding MDU results awaiting the write port.
// The head is read combinationally so it can be written in the same cycle
// it is granted; this keeps the storage in LUT RAM rather than block RAM.
module wb_result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline write-back
// and buffered MDU results, forcing a stall if an MDU result starves.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;

    logic              pipe_wr, mdu_wr_nz, fifo_ne, fifo_room;
    logic              pop, push, bypass, mdu_ready;
    logic              rf_we, pipe_stall;
    logic [ADDR_W-1:0] rf_addr, head_addr;
    logic [DATA_W-1:0] rf_data, head_data;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  fifo_count;

    assign pipe_wr   = bus.pipe_we && (bus.pipe_addr != ADDR_W'(REG_ZERO));
    assign mdu_wr_nz = bus.mdu_valid && (bus.mdu_addr != ADDR_W'(REG_ZERO));
    assign fifo_ne   = (fifo_count != '0);
    assign fifo_room = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign {head_addr, head_data} = head;

    // Port grant, stall, FIFO pop and next FSM/starvation state.
    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_data    = '0;
        pipe_stall = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;
        state_d    = state_q;
        starve_d   = starve_q;
        if (!reset) begin
            if (state_q == ARB_FORCE) begin
                pipe_stall = 1'b1;
                if (fifo_ne) begin
                    rf_we   = 1'b1;
                    rf_addr = head_addr;
                    rf_data = head_data;
                    pop     = 1'b1;
                end
                state_d = ARB_NORMAL;
            end else if (pipe_wr) begin
                rf_we   = 1'b1;
                rf_addr = bus.pipe_addr;
                rf_data = bus.pipe_data;
            end else if (fifo_ne) begin
                rf_we   = 1'b1;
                rf_addr = head_addr;
                rf_data = head_data;
                pop     = 1'b1;
            end else if (mdu_wr_nz) begin
                rf_we   = 1'b1;
                rf_addr = bus.mdu_addr;
                rf_data = bus.mdu_data;
                bypass  = 1'b1;
            end

            // Count consecutive cycles the head is denied, saturating.
            if (!fifo_ne || pop)
                starve_d = '0;
            else if (starve_q != STARVE_MAX)
                starve_d = starve_q + 1'b1;

            if (state_q == ARB_NORMAL && starve_d == STARVE_MAX)
                state_d = ARB_FORCE;
        end
    end

    // Acceptance is based on the registered count; $0 results are accepted and dropped.
    always_comb begin
        mdu_ready = !reset && (fifo_room || bypass);
        push      = bus.mdu_valid && mdu_ready && !bypass && mdu_wr_nz;
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    wb_result_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({bus.mdu_addr, bus.mdu_data}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign bus.rf_we      = rf_we;
    assign bus.rf_addr    = rf_addr;
    assign bus.rf_data    = rf_data;
    assign bus.pipe_stall = pipe_stall;
    assign bus.mdu_ready  = mdu_ready;
    assign bus.fifo_count = fifo_count;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port after the write-back stage.
- Shares that port between the in-order pipeline write-back (its mux result, destination register and RegWrite) and results returning from the multi-cycle multiply/divide unit (MDU).
- MDU results are buffered in a small in-order FIFO and drained on idle write-back cycles.
- A starvation counter forces a pipeline stall so a pending MDU result is guaranteed to retire.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive denied cycles before a forced FIFO write.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  RegWrite from write-back stage.
- pipe_addr  in  ADDR_W  write-back destination register.
- pipe_data  in  DATA_W  write-back data (MemtoReg mux output).
- mdu_valid  in  1  MDU result available.
- mdu_addr  in  ADDR_W  MDU destination register.
- mdu_data  in  DATA_W  MDU result.
- mdu_ready  out  1  result accepted this cycle when mdu_valid=1.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file write address.
- rf_data  out  DATA_W  register-file write data.
- pipe_stall  out  1  hold the write-back instruction; it is re-presented next cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries (registered).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FIFO empty, fifo_count=0, state=ARB_NORMAL, starve_cnt=0.
- While reset=1: rf_we=0, mdu_ready=0, pipe_stall=0. rf_addr and rf_data are don't-care.
- Effective pipeline write: pipe_wr = pipe_we && (pipe_addr != 0). A write to $0 never reaches the port and leaves it free.
- Outputs are combinational from the current state and inputs. FIFO, counter and FSM update on the clock edge. Write latency is 0 cycles from grant.
- FSM state ARB_NORMAL, priority order:
  - pipe_wr: grant pipeline; rf_* = pipe_*; pipe_stall=0.
  - Else FIFO non-empty: write the FIFO head; pop at the edge.
  - Else mdu_valid && mdu_addr!=0: bypass. Write mdu_* directly, mdu_ready=1, nothing enqueued.
  - Else: rf_we=0.
- FSM state ARB_FORCE:
  - pipe_stall=1.
  - FIFO head written and popped regardless of pipe_wr.
  - Next state is ARB_NORMAL (exactly one forced write per entry).
- mdu_ready:
  - 1 when fifo_count < FIFO_DEPTH, or the bypass applies.
  - Based on the registered count, so a full FIFO does not accept in the same cycle it pops.
  - mdu_valid with mdu_addr=0 is accepted and discarded.
- Enqueue happens when mdu_valid && mdu_ready && the bypass is not taken. Simultaneous enqueue and pop are allowed; the count stays unchanged.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and its head is not written.
  - Clears on any FIFO write and when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Transition ARB_NORMAL to ARB_FORCE at the edge where starve_cnt reaches STARVE_LIMIT.
- FIFO order is strict FIFO. MDU results retire in acceptance order.
- WAW ordering between the pipeline and MDU destinations is guaranteed upstream by the issue scoreboard. This block neither checks nor reorders it.
- Reset mid-operation: all pending FIFO entries are discarded and a forced cycle is abandoned. Next cycle is ARB_NORMAL with an empty FIFO.
- Write pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - arbiter state encoding: ARB_NORMAL=1'b0, ARB_FORCE=1'b1.
  - REG_ZERO constant (5'd0).
  - Write-request struct/bundle {we, addr, data} used by the write-back and register-file interfaces.
- One sub-module, wb_result_fifo: parameterised sync FIFO with push/pop/count/head. The arbiter FSM and starvation counter stay in the top.

Test Plan:
- Reset held 3 cycles with mdu_valid=1 and pipe_we=1 -> rf_we=0, mdu_ready=0, pipe_stall=0. After release fifo_count=0.
- Pipeline idle, FIFO empty, mdu_valid with addr=9, data=0x1234 -> same cycle rf_we=1, rf_addr=9, rf_data=0x1234, mdu_ready=1; fifo_count stays 0.
- Two MDU results (r3=0xA, r4=0xB) on consecutive cycles while pipe_we=1 to r7 -> fifo_count=2 and a third result sees mdu_ready=0.
  - Drop pipe_we: r3 written first, then r4; count goes 2 to 1 to 0.
- FIFO holds one entry and pipe_we=1 to nonzero addr every cycle -> entry waits 4 cycles.
  - 5th cycle: pipe_stall=1 and rf_addr = FIFO head.
  - 6th cycle: pipeline write proceeds; starve_cnt=0.
- pipe_we=1 with pipe_addr=0 while the FIFO holds r5=0x55 -> FIFO head written that cycle, no stall.
- reset asserted while in ARB_FORCE with fifo_count=2 -> next cycle fifo_count=0, pipe_stall=0, no stale write after release.
